// File: rtl/vga_timing_gen_if.sv
// Pixel-source and VGA-pin bundle for vga_timing_gen.
// master = the generator; slave = the framebuffer/renderer and DAC side.
interface vga_timing_gen_if #(
  parameter int COLOR_W = 4,
  parameter int COORD_W = 12
);
  logic                   pix_ce;
  logic                   enable;
  logic [1:0]             mode;
  logic                   req;
  logic [COORD_W-1:0]     x;
  logic [COORD_W-1:0]     y;
  logic [3*COLOR_W-1:0]   pix_in;
  logic [COLOR_W-1:0]     red;
  logic [COLOR_W-1:0]     green;
  logic [COLOR_W-1:0]     blue;
  logic                   hsync;
  logic                   vsync;
  logic                   de;
  logic                   frame_start;
  logic                   line_start;

  modport master (
    input  pix_ce, enable, mode, pix_in,
    output req, x, y, red, green, blue, hsync, vsync, de, frame_start, line_start
  );

  modport slave (
    output pix_ce, enable, mode, pix_in,
    input  req, x, y, red, green, blue, hsync, vsync, de, frame_start, line_start
  );
endinterface

// File: rtl/vga_timing_gen.sv
// Programmable VGA raster timing generator with test-pattern substitution.
// Sync/de/strobes and pattern colour ride a PIPE_LAT-deep line matched to pix_in latency.

// One colour channel of the output stage: selects source, blanks outside de.
module vga_chan_out #(
  parameter int COLOR_W = 4
) (
  input  logic               clk,
  input  logic               nrst,
  input  logic               clr,
  input  logic               ce,
  input  logic               de,
  input  logic               use_ext,
  input  logic [COLOR_W-1:0] ext,
  input  logic [COLOR_W-1:0] pat,
  output logic [COLOR_W-1:0] col
);
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst)      col <= '0;
    else if (clr)   col <= '0;
    else if (ce)    col <= !de ? '0 : (use_ext ? ext : pat);
  end
endmodule

module vga_timing_gen #(
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int H_ACTIVE   = 640,
  parameter int H_FP       = 16,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  parameter int V_ACTIVE   = 480,
  parameter int V_FP       = 10,
  parameter bit HSYNC_POL  = 1'b0,
  parameter bit VSYNC_POL  = 1'b0,
  parameter int COLOR_W    = 4,
  parameter int COORD_W    = 12,
  parameter int PIPE_LAT   = 2,
  parameter int CHECK_LOG2 = 5
) (
  input logic            clk,
  input logic            nrst,
  vga_timing_gen_if.master bus
);
  localparam int unsigned H_TOTAL = H_SYNC + H_BP + H_ACTIVE + H_FP;
  localparam int unsigned V_TOTAL = V_SYNC + V_BP + V_ACTIVE + V_FP;
  localparam int unsigned H_OFF   = H_SYNC + H_BP;
  localparam int unsigned H_END   = H_OFF + H_ACTIVE;
  localparam int unsigned V_OFF   = V_SYNC + V_BP;
  localparam int unsigned V_END   = V_OFF + V_ACTIVE;
  localparam int unsigned BAR_W   = (H_ACTIVE / 8 > 0) ? H_ACTIVE / 8 : 1;

  typedef struct packed {
    logic                    hs;
    logic                    vs;
    logic                    de;
    logic                    fs;
    logic                    ls;
    logic [1:0]              mode;
    logic [2:0][COLOR_W-1:0] pat;
  } pipe_t;

  logic [COORD_W-1:0] hcnt, vcnt;
  logic [31:0]        hc32, vc32;
  logic               h_last, v_last, at_origin;
  logic [1:0]         mode_q;

  assign hc32      = 32'(hcnt);
  assign vc32      = 32'(vcnt);
  assign h_last    = (hc32 == H_TOTAL - 1);
  assign v_last    = (vc32 == V_TOTAL - 1);
  assign at_origin = (hcnt == '0) && (vcnt == '0);

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      hcnt <= '0;
      vcnt <= '0;
    end else if (!bus.enable) begin
      hcnt <= '0;
      vcnt <= '0;
    end else if (bus.pix_ce) begin
      if (h_last) begin
        hcnt <= '0;
        vcnt <= v_last ? '0 : vcnt + 1'b1;
      end else begin
        hcnt <= hcnt + 1'b1;
      end
    end
  end

  // Mode is latched only at the origin so a frame is never split between two sources.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst)                                      mode_q <= 2'd0;
    else if (bus.enable && bus.pix_ce && at_origin) mode_q <= bus.mode;
  end

  logic               req_c;
  logic [COORD_W-1:0] x_c, y_c;

  assign req_c = (hc32 >= H_OFF) && (hc32 < H_END) && (vc32 >= V_OFF) && (vc32 < V_END);
  assign x_c   = req_c ? COORD_W'(hc32 - H_OFF) : '0;
  assign y_c   = req_c ? COORD_W'(vc32 - V_OFF) : '0;

  assign bus.req = req_c;
  assign bus.x   = x_c;
  assign bus.y   = y_c;

  // Bar index is the count of bar boundaries already passed; saturates at 7.
  logic [2:0] bar;
  logic [2:0] bar_rgb;
  logic       chk_on;

  always_comb begin
    bar = 3'd0;
    for (int k = 1; k < 8; k++)
      if (32'(x_c) >= 32'(k) * BAR_W) bar = 3'(k);
  end

  always_comb begin
    case (bar)
      3'd0:    bar_rgb = 3'b111;
      3'd1:    bar_rgb = 3'b110;
      3'd2:    bar_rgb = 3'b011;
      3'd3:    bar_rgb = 3'b010;
      3'd4:    bar_rgb = 3'b101;
      3'd5:    bar_rgb = 3'b100;
      3'd6:    bar_rgb = 3'b001;
      default: bar_rgb = 3'b000;
    endcase
  end

  assign chk_on = x_c[CHECK_LOG2] ^ y_c[CHECK_LOG2];

  pipe_t issue, tail;

  always_comb begin
    issue      = '0;
    issue.hs   = (hc32 < 32'(H_SYNC));
    issue.vs   = (vc32 < 32'(V_SYNC));
    issue.de   = req_c;
    issue.fs   = at_origin;
    issue.ls   = (hcnt == '0);
    issue.mode = mode_q;
    case (mode_q)
      2'd1:    for (int c = 0; c < 3; c++) issue.pat[c] = {COLOR_W{bar_rgb[c]}};
      2'd2:    issue.pat = {(3*COLOR_W){chk_on}};
      default: issue.pat = '0;
    endcase
  end

  generate
    if (PIPE_LAT == 0) begin : g_nopipe
      assign tail = issue;
    end else begin : g_pipe
      pipe_t vld_pipe [PIPE_LAT];

      always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
          for (int i = 0; i < PIPE_LAT; i++) vld_pipe[i] <= '0;
        end else if (!bus.enable) begin
          for (int i = 0; i < PIPE_LAT; i++) vld_pipe[i] <= '0;
        end else if (bus.pix_ce) begin
          vld_pipe[0] <= issue;
          for (int i = 1; i < PIPE_LAT; i++) vld_pipe[i] <= vld_pipe[i-1];
        end
      end

      assign tail = vld_pipe[PIPE_LAT-1];
    end
  endgenerate

  logic hsync_q, vsync_q, de_q, fs_q, ls_q;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      hsync_q <= ~HSYNC_POL;
      vsync_q <= ~VSYNC_POL;
      de_q    <= 1'b0;
      fs_q    <= 1'b0;
      ls_q    <= 1'b0;
    end else if (!bus.enable) begin
      hsync_q <= ~HSYNC_POL;
      vsync_q <= ~VSYNC_POL;
      de_q    <= 1'b0;
      fs_q    <= 1'b0;
      ls_q    <= 1'b0;
    end else if (bus.pix_ce) begin
      hsync_q <= tail.hs ~^ HSYNC_POL;
      vsync_q <= tail.vs ~^ VSYNC_POL;
      de_q    <= tail.de;
      fs_q    <= tail.fs;
      ls_q    <= tail.ls;
    end
  end

  // Channel 2 is red, matching the {r,g,b} packing of pix_in.
  logic [2:0][COLOR_W-1:0] rgb_q;

  for (genvar c = 0; c < 3; c++) begin : g_chan
    vga_chan_out #(.COLOR_W(COLOR_W)) u_chan (
      .clk     (clk),
      .nrst    (nrst),
      .clr     (!bus.enable),
      .ce      (bus.pix_ce),
      .de      (tail.de),
      .use_ext (tail.mode == 2'd0),
      .ext     (bus.pix_in[c*COLOR_W +: COLOR_W]),
      .pat     (tail.pat[c]),
      .col     (rgb_q[c])
    );
  end

  assign bus.red         = rgb_q[2];
  assign bus.green       = rgb_q[1];
  assign bus.blue        = rgb_q[0];
  assign bus.hsync       = hsync_q;
  assign bus.vsync       = vsync_q;
  assign bus.de          = de_q;
  assign bus.frame_start = fs_q;
  assign bus.line_start  = ls_q;
endmodule

// File: tb/tb_vga_timing_gen.sv
// Randomized bench for vga_timing_gen on a small raster, against a tick-count model.
module tb_vga_timing_gen;
  localparam int HS = 4, HBP = 3, HA = 20, HFP = 2;
  localparam int VS = 2, VBP = 2, VA = 6, VFP = 1;
  localparam bit HPOL = 1'b1, VPOL = 1'b0;
  localparam int CW = 4, XW = 8, LAT = 2, CL = 2;
  localparam int HT = HS + HBP + HA + HFP;
  localparam int VT = VS + VBP + VA + VFP;
  localparam int F = HT * VT;
  localparam int HOFF = HS + HBP, VOFF = VS + VBP;

  logic clk = 1'b0;
  logic nrst = 1'b0;
  always #5 clk = ~clk;

  vga_timing_gen_if #(.COLOR_W(CW), .COORD_W(XW)) bus ();

  vga_timing_gen #(
    .H_SYNC(HS), .H_BP(HBP), .H_ACTIVE(HA), .H_FP(HFP),
    .V_SYNC(VS), .V_BP(VBP), .V_ACTIVE(VA), .V_FP(VFP),
    .HSYNC_POL(HPOL), .VSYNC_POL(VPOL), .COLOR_W(CW), .COORD_W(XW),
    .PIPE_LAT(LAT), .CHECK_LOG2(CL)
  ) dut (
    .clk  (clk),
    .nrst (nrst),
    .bus  (bus)
  );

  int total = 0, bad = 0;
  int ticks = 0;
  int fmode [4];
  logic [CW-1:0] salt;
  logic [3*CW-1:0] srcq [$];
  logic [2:0] bar_tab [8] = '{3'b111, 3'b110, 3'b011, 3'b010, 3'b101, 3'b100, 3'b001, 3'b000};

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", tag, act, exp, $time);
    end
  endtask

  function automatic bit in_act(int h, int v);
    return h >= HOFF && h < HOFF + HA && v >= VOFF && v < VOFF + VA;
  endfunction

  function automatic logic [3*CW-1:0] src_pix(logic [XW-1:0] x, logic [XW-1:0] y);
    return {x[3:0], y[3:0], salt};
  endfunction

  function automatic logic [2*XW:0] exp_coord(int t);
    int h = t % HT, v = (t / HT) % VT;
    if (in_act(h, v)) return {1'b1, XW'(h - HOFF), XW'(v - VOFF)};
    return '0;
  endfunction

  // {hsync, vsync, de, frame_start, line_start}
  function automatic logic [4:0] exp_sync(int t);
    int p, h, v;
    if (t < LAT + 1) return {~HPOL, ~VPOL, 3'b000};
    p = t - LAT - 1; h = p % HT; v = (p / HT) % VT;
    return {(h < HS) ? HPOL : ~HPOL, (v < VS) ? VPOL : ~VPOL,
            in_act(h, v), (h == 0 && v == 0), (h == 0)};
  endfunction

  function automatic logic [3*CW-1:0] exp_rgb(int t);
    int p, h, v, x, y, b;
    logic [2:0] c;
    if (t < LAT + 1) return '0;
    p = t - LAT - 1; h = p % HT; v = (p / HT) % VT;
    if (!in_act(h, v)) return '0;
    x = h - HOFF; y = v - VOFF;
    case (fmode[(p / F) % 4])
      0: return src_pix(XW'(x), XW'(y));
      1: begin
        b = x / (HA / 8);
        if (b > 7) b = 7;
        c = bar_tab[b];
        return {{CW{c[2]}}, {CW{c[1]}}, {CW{c[0]}}};
      end
      2: return (((x >> CL) ^ (y >> CL)) & 1) != 0 ? {3*CW{1'b1}} : '0;
      default: return '0;
    endcase
  endfunction

  task automatic step();
    bit ce_now = bus.pix_ce;
    bit en_now = bus.enable;
    bit rs_now = nrst;
    int m = int'(bus.mode);
    bit cleared = 1'b0, ticked = 1'b0;
    @(posedge clk);
    if (!rs_now || !en_now) begin
      ticks = 0; cleared = 1'b1;
    end else if (ce_now) begin
      if (ticks % F == 0) fmode[(ticks / F) % 4] = m;
      ticks++; ticked = 1'b1;
    end
    #1;
    chk("coord", {bus.req, bus.x, bus.y}, exp_coord(ticks));
    chk("sync", {bus.hsync, bus.vsync, bus.de, bus.frame_start, bus.line_start}, exp_sync(ticks));
    chk("rgb", {bus.red, bus.green, bus.blue}, exp_rgb(ticks));
    if (cleared) srcq.delete();
    if (cleared || ticked) begin
      srcq.push_front(src_pix(bus.x, bus.y));
      if (srcq.size() > LAT + 1) void'(srcq.pop_back());
    end
    bus.pix_in = (srcq.size() > LAT) ? srcq[LAT] : (3*CW)'($urandom());
  endtask

  // Async reset asserted between edges; outputs must idle before the next edge.
  task automatic rst_pulse(input int hold);
    #2 nrst = 1'b0;
    #1;
    chk("rst_imm_sync", {bus.hsync, bus.vsync, bus.de, bus.frame_start, bus.line_start},
        {~HPOL, ~VPOL, 3'b000});
    chk("rst_imm_rgb", {bus.red, bus.green, bus.blue}, 0);
    repeat (hold) step();
    nrst = 1'b1;
  endtask

  initial begin
    int last_fs, de_cnt, cyc, run_hs, run_ls, dens;
    bit skip_hs, skip_ls;
    salt = CW'($urandom());
    bus.pix_ce = 1'b0; bus.enable = 1'b0; bus.mode = 2'd0; bus.pix_in = '0;
    for (int i = 0; i < 4; i++) fmode[i] = 0;
    repeat (3) step();

    // Free-running pixel clock; bars, then a mid-frame switch to checkerboard, then external.
    nrst = 1'b1; bus.enable = 1'b1; bus.mode = 2'd1; bus.pix_ce = 1'b1;
    last_fs = -1; de_cnt = 0;
    for (cyc = 0; cyc < 4 * F + 10; cyc++) begin
      if (cyc == F + (VOFF + 3) * HT) bus.mode = 2'd2;
      if (cyc == 2 * F + 50) bus.mode = 2'd0;
      step();
      if (bus.frame_start) begin
        if (last_fs >= 0) begin
          chk("fs_period", 64'(cyc - last_fs), 64'(F));
          chk("de_per_frame", 64'(de_cnt), 64'(HA * VA));
        end
        last_fs = cyc; de_cnt = 0;
      end
      de_cnt += int'(bus.de);
    end

    // Pixel clock every 4th cycle: widths scale by 4; enable dropped mid-line later on.
    bus.mode = 2'd1;
    run_hs = 0; run_ls = 0; skip_hs = 1'b1; skip_ls = 1'b1;
    for (int i = 0; i < 8 * F + 40; i++) begin
      bus.pix_ce = (i % 4 == 0);
      if (i == 5 * F + 4 * (HOFF + 5)) bus.enable = 1'b0;
      if (i == 5 * F + 4 * (HOFF + 5) + 3) bus.enable = 1'b1;
      step();
      if (i < 4 * F) begin
        if (bus.hsync == HPOL) run_hs++;
        else if (run_hs > 0) begin
          if (!skip_hs) chk("hs_width", 64'(run_hs), 64'(4 * HS));
          skip_hs = 1'b0; run_hs = 0;
        end
        if (bus.line_start) run_ls++;
        else if (run_ls > 0) begin
          if (!skip_ls) chk("ls_width", 64'(run_ls), 64'(4));
          skip_ls = 1'b0; run_ls = 0;
        end
      end
    end

    // Random pixel-clock density, mode changes, enable drops and reset pulses.
    bus.pix_ce = 1'b1;
    repeat (F / 2) step();
    rst_pulse(2);
    dens = 100;
    for (int i = 0; i < 6000; i++) begin
      if (i % 500 == 0) dens = int'($urandom_range(20, 100));
      bus.pix_ce = ($urandom_range(0, 99) < dens);
      if ($urandom_range(0, 299) == 0) bus.mode = 2'($urandom());
      if ($urandom_range(0, 1499) == 0) bus.enable = 1'b0;
      else if (!bus.enable && $urandom_range(0, 3) == 0) bus.enable = 1'b1;
      if ($urandom_range(0, 1999) == 0) rst_pulse(int'($urandom_range(1, 3)));
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
